// File: rtl/cnu_minsum_serial.sv
// ---------------------------------------------------------------------------
// cnu_minsum_serial
//   Serial offset min-sum check-node unit. Collects one sign-magnitude
//   variable-to-check message per cycle for a parity-check row. It keeps the
//   two smallest magnitudes, the position of the smallest, the XOR of all
//   signs and the per-edge signs. It then emits one check-to-variable message
//   per edge, in the same order and in sign-magnitude format.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     input message valid
//   o_ready     input accepted this cycle (high while collecting)
//   i_data      sign-magnitude input {sign, magnitude[DATA_W-2:0]}
//   i_last      final edge of the row, qualified by i_valid
//   o_valid     output message valid (high while emitting)
//   i_ready     downstream accepts the output message
//   o_data      sign-magnitude output message
//   o_last      final output edge of the row
//   o_overflow  one-cycle pulse: row closed at DEG_MAX edges without i_last
// ---------------------------------------------------------------------------
module cnu_minsum_serial #(
    parameter int DATA_W  = 8,
    parameter int DEG_MAX = 32,
    parameter int OFFSET  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_overflow
);

    localparam int MW = DATA_W - 1;
    localparam int IW = $clog2(DEG_MAX);
    // One extra bit so that a full-length row degree (DEG_MAX) is representable.
    localparam int CW = IW + 1;

    localparam logic S_COLLECT = 1'b0;
    localparam logic S_EMIT    = 1'b1;

    localparam logic [MW-1:0] MAG_MAX = '1;
    localparam logic [MW-1:0] OFF_M   = MW'(OFFSET);

    // Offset subtraction with clamp at zero.
    function automatic logic [MW-1:0] sub_offset_sat(input logic [MW-1:0] mag);
        return (mag > OFF_M) ? (mag - OFF_M) : '0;
    endfunction

    logic               state;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      k;
    logic [CW-1:0]      deg;
    logic [CW-1:0]      idx;
    logic [MW-1:0]      min1;
    logic [MW-1:0]      min2;
    logic               sgn_tot;
    logic               overflow;
    logic [DEG_MAX-1:0] sign_store;

    logic          in_xfer;
    logic          out_xfer;
    logic          cnt_at_max;
    logic          k_is_last;
    logic [MW-1:0] in_mag;
    logic          in_sgn;
    logic [MW-1:0] sel_mag;
    logic [MW-1:0] mag_o;
    logic          sign_o;

    assign in_mag     = i_data[MW-1:0];
    assign in_sgn     = i_data[DATA_W-1];
    assign in_xfer    = i_valid && (state == S_COLLECT);
    assign out_xfer   = (state == S_EMIT) && i_ready;
    assign cnt_at_max = (cnt == CW'(DEG_MAX - 1));
    assign k_is_last  = (k == deg - CW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_COLLECT;
            cnt      <= '0;
            k        <= '0;
            deg      <= '0;
            idx      <= '0;
            min1     <= MAG_MAX;
            min2     <= MAG_MAX;
            sgn_tot  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= in_xfer && !i_last && cnt_at_max;
            case (state)
                S_COLLECT: begin
                    if (in_xfer) begin
                        sgn_tot <= sgn_tot ^ in_sgn;
                        // Strict compares: an equal later magnitude never
                        // displaces the first minimum, it lands in min2.
                        if (in_mag < min1) begin
                            min2 <= min1;
                            min1 <= in_mag;
                            idx  <= cnt;
                        end else if (in_mag < min2) begin
                            min2 <= in_mag;
                        end
                        cnt <= cnt + CW'(1);
                        if (i_last || cnt_at_max) begin
                            state <= S_EMIT;
                            deg   <= cnt + CW'(1);
                            k     <= '0;
                        end
                    end
                end
                default: begin
                    if (out_xfer) begin
                        if (k_is_last) begin
                            // Reload the row accumulators on re-entry to COLLECT.
                            state   <= S_COLLECT;
                            cnt     <= '0;
                            min1    <= MAG_MAX;
                            min2    <= MAG_MAX;
                            sgn_tot <= 1'b0;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Per-edge signs are pure data; every entry read in EMIT was written in
    // the same row, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (in_xfer) begin
            sign_store[cnt[IW-1:0]] <= in_sgn;
        end
    end

    // Output message from registered state and k only.
    always_comb begin
        sel_mag = (k == idx) ? min2 : min1;
        mag_o   = sub_offset_sat(sel_mag);
        // A zero magnitude is always reported positive.
        sign_o  = (mag_o != '0) && (sgn_tot ^ sign_store[k[IW-1:0]]);
    end

    assign o_ready    = (state == S_COLLECT);
    assign o_valid    = (state == S_EMIT);
    assign o_data     = (state == S_EMIT) ? {sign_o, mag_o} : '0;
    assign o_last     = (state == S_EMIT) && k_is_last;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// ---------------------------------------------------------------------------
// tb_cnu_minsum_serial
//   Self-checking bench for cnu_minsum_serial. Three instances share the
//   stimulus: sel=0 (OFFSET=0, DEG_MAX=32), sel=1 (OFFSET=2, DEG_MAX=32) and
//   sel=2 (OFFSET=0, DEG_MAX=4). Only the selected instance sees i_valid.
//   Expected outputs come from a table and from a leave-one-out reference
//   model: each edge's output is the minimum magnitude and the sign XOR over
//   all other edges of the row.
// ---------------------------------------------------------------------------
module tb_cnu_minsum_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_rdy;
    int         sel;

    logic       rdy_v   [3];
    logic       ovld_v  [3];
    logic       olast_v [3];
    logic       oovf_v  [3];
    logic [7:0] dat_v   [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] row_in  [32];
    logic [7:0] exp_out [32];
    int         row_deg;
    int         offsets [3] = '{0, 2, 0};

    typedef struct {
        int         sel;
        int         deg;
        logic [7:0] din  [4];
        logic [7:0] dout [4];
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    cnu_minsum_serial #(.DATA_W(8), .DEG_MAX(32), .OFFSET(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld && sel == 0), .o_ready(rdy_v[0]),
        .i_data(in_data), .i_last(in_last), .o_valid(ovld_v[0]), .i_ready(out_rdy),
        .o_data(dat_v[0]), .o_last(olast_v[0]), .o_overflow(oovf_v[0]));

    cnu_minsum_serial #(.DATA_W(8), .DEG_MAX(32), .OFFSET(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld && sel == 1), .o_ready(rdy_v[1]),
        .i_data(in_data), .i_last(in_last), .o_valid(ovld_v[1]), .i_ready(out_rdy),
        .o_data(dat_v[1]), .o_last(olast_v[1]), .o_overflow(oovf_v[1]));

    cnu_minsum_serial #(.DATA_W(8), .DEG_MAX(4), .OFFSET(0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld && sel == 2), .o_ready(rdy_v[2]),
        .i_data(in_data), .i_last(in_last), .o_valid(ovld_v[2]), .i_ready(out_rdy),
        .o_data(dat_v[2]), .o_last(olast_v[2]), .o_overflow(oovf_v[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Leave-one-out reference: output k ignores edge k entirely.
    function automatic logic [7:0] ref_out(input int k);
        int   mag = 127;
        logic sgn = 1'b0;
        int   mo;
        for (int j = 0; j < row_deg; j++) begin
            if (j != k) begin
                if (int'(row_in[j][6:0]) < mag) mag = int'(row_in[j][6:0]);
                sgn = sgn ^ row_in[j][7];
            end
        end
        mo = (mag > offsets[sel]) ? mag - offsets[sel] : 0;
        if (mo == 0) sgn = 1'b0;
        return {sgn, 7'(mo)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            in_vld  = 1'b1;
            in_data = row_in[i];
            in_last = with_last && (i == n - 1);
            check("in_ready", rdy_v[sel], 1'b1);
            check("in_no_valid", ovld_v[sel], 1'b0);
            tick();
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain_row(input int n, input int stall_pct, input int exp_ovf);
        int         k = 0;
        int         guard = 0;
        int         ovf = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] pd = '0;
        logic       pl = 1'b0;
        check("first_out_valid", ovld_v[sel], 1'b1);
        while (k < n && guard < 400) begin
            out_rdy = ($urandom_range(99) >= stall_pct);
            if (oovf_v[sel]) ovf++;
            check("out_valid", ovld_v[sel], 1'b1);
            check("out_no_ready", rdy_v[sel], 1'b0);
            if (prev_stall) begin
                check("hold_data", dat_v[sel], pd);
                check("hold_last", olast_v[sel], pl);
            end
            if (out_rdy) begin
                check($sformatf("data[%0d]", k), dat_v[sel], exp_out[k]);
                check($sformatf("last[%0d]", k), olast_v[sel], (k == n - 1));
                k++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                pd = dat_v[sel];
                pl = olast_v[sel];
            end
            tick();
            guard++;
        end
        if (k < n) check("drain_timeout", k, n);
        out_rdy = 1'b1;
        check("overflow_pulses", ovf, exp_ovf);
        check("ready_after", rdy_v[sel], 1'b1);
        check("valid_after", ovld_v[sel], 1'b0);
    endtask

    task automatic model_fill();
        for (int k = 0; k < row_deg; k++) exp_out[k] = ref_out(k);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", rdy_v[sel], 1'b1);
        check("rst_valid", ovld_v[sel], 1'b0);
        check("rst_data", dat_v[sel], 8'h00);
        check("rst_last", olast_v[sel], 1'b0);
        check("rst_ovf", oovf_v[sel], 1'b0);
    endtask

    initial begin
        // Expected values follow the check-node rules directly.
        tbl[0].sel = 0; tbl[0].deg = 4;
        tbl[0].din  = '{8'h05, 8'h83, 8'h07, 8'h83};
        tbl[0].dout = '{8'h03, 8'h83, 8'h03, 8'h83};
        tbl[1].sel = 1; tbl[1].deg = 3;
        tbl[1].din  = '{8'h01, 8'h04, 8'h86, 8'h00};
        tbl[1].dout = '{8'h82, 8'h00, 8'h00, 8'h00};
        tbl[2].sel = 0; tbl[2].deg = 1;
        tbl[2].din  = '{8'h89, 8'h00, 8'h00, 8'h00};
        tbl[2].dout = '{8'h7F, 8'h00, 8'h00, 8'h00};
        tbl[3].sel = 1; tbl[3].deg = 2;
        tbl[3].din  = '{8'h8A, 8'h0C, 8'h00, 8'h00};
        tbl[3].dout = '{8'h0A, 8'h88, 8'h00, 8'h00};

        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b1; sel = 0;
        tick(); tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            check_reset_outputs();
        end
        sel = 0;
        rst_n = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 4; i++) begin
            sel = tbl[i].sel;
            row_deg = tbl[i].deg;
            for (int j = 0; j < row_deg; j++) begin
                row_in[j]  = tbl[i].din[j];
                exp_out[j] = tbl[i].dout[j];
            end
            push_row(row_deg, 1'b1);
            drain_row(row_deg, 0, 0);
        end

        // Overflow: DEG_MAX=4, no i_last; the 5th input waits through EMIT.
        sel = 2;
        row_deg = 4;
        row_in[0] = 8'h11; row_in[1] = 8'h86; row_in[2] = 8'h09; row_in[3] = 8'h20;
        model_fill();
        push_row(4, 1'b0);
        in_vld = 1'b1; in_data = 8'h93; in_last = 1'b1;
        drain_row(4, 0, 1);
        tick();
        in_vld = 1'b0; in_last = 1'b0;
        row_deg = 1; row_in[0] = 8'h93;
        model_fill();
        drain_row(1, 0, 0);

        // Degree-6 row under heavy backpressure.
        sel = 0;
        row_deg = 6;
        for (int j = 0; j < 6; j++) row_in[j] = 8'($urandom);
        model_fill();
        push_row(6, 1'b1);
        drain_row(6, 50, 0);

        // Reset in the middle of a row.
        sel = 0;
        row_in[0] = 8'h81; row_in[1] = 8'h01;
        push_row(2, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        tick(); tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        row_deg = 3;
        row_in[0] = 8'h14; row_in[1] = 8'h92; row_in[2] = 8'h28;
        model_fill();
        push_row(3, 1'b1);
        drain_row(3, 0, 0);

        // Random rows across all three instances.
        for (int r = 0; r < 30; r++) begin
            sel = $urandom_range(2);
            row_deg = (sel == 2) ? $urandom_range(1, 4) : $urandom_range(1, 12);
            for (int j = 0; j < row_deg; j++) row_in[j] = 8'($urandom);
            if ($urandom_range(3) == 0 && row_deg > 1) row_in[row_deg - 1] = row_in[0];
            model_fill();
            push_row(row_deg, 1'b1);
            drain_row(row_deg, 30, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
